store_byte_lane_packer: RTL and testbench

- Write-side counterpart of the load-path extension logic: narrows and aligns store data for sb/sh/sw into byte-lane writes toward data memory.
- Sits between the EX/MEM stage and the data-memory port.
- Holds one request in a registered output slot until memory accepts it.
- Raises an address-error (AdES) pulse for misaligned stores and suppresses the memory write.

---
 rtl/store_byte_lane_packer.sv | 107 ++++++++++
 tb/tb_store_byte_lane_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_byte_lane_packer.sv
// Store-side byte-lane packer: aligns sb/sh/sw data into lane writes, holds one
// request in an output slot until memory accepts it, and flags misaligned stores.

module store_byte_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] store_type,
  input  logic [1:0] offset,
  input  logic [7:0] word_byte,
  input  logic [7:0] half_byte,
  input  logic [7:0] low_byte,
  output logic       we,
  output logic [7:0] wbyte
);
  localparam logic [1:0] IDX = LANE[1:0];

  always_comb begin
    we    = 1'b0;
    wbyte = 8'h00;
    case (store_type)
      2'b00: begin we = 1'b1;              wbyte = word_byte; end
      2'b01: begin we = (offset[1] == IDX[1]); wbyte = half_byte; end
      2'b10: begin we = (offset == IDX);   wbyte = low_byte;  end
      default: begin we = 1'b0;            wbyte = 8'h00;     end
    endcase
  end
endmodule

module store_byte_lane_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       store_type,
  input  logic [31:0]      addr,
  input  logic [31:0]      data,
  input  logic             flush,
  output logic             dm_en,
  input  logic             dm_ready,
  output logic [3:0]       dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             exc_ades,
  output logic [31:0]      exc_badvaddr,
  output logic [CNT_W-1:0] store_count
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, PEND} state_t;
  state_t state;

  logic accept, misalign, reserved, fault, good, done;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_byte;

  assign req_ready = !flush && (state == IDLE || dm_ready);
  assign accept    = req_valid && req_ready;
  assign misalign  = (store_type == 2'b00 && addr[1:0] != 2'b00) ||
                     (store_type == 2'b01 && addr[0]);
  assign reserved  = (store_type == 2'b11);
  assign fault     = accept && misalign;
  assign good      = accept && !misalign && !reserved;
  // A held write completes whenever memory takes it, even during a flush.
  assign done      = (state == PEND) && dm_ready;
  assign dm_en     = (state == PEND);

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      store_byte_lane #(.LANE(g)) u_lane (
        .store_type (store_type),
        .offset     (addr[1:0]),
        .word_byte  (data[8*g +: 8]),
        .half_byte  (data[8*(g%2) +: 8]),
        .low_byte   (data[7:0]),
        .we         (lane_we[g]),
        .wbyte      (lane_byte[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      dm_we        <= '0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      exc_ades     <= 1'b0;
      exc_badvaddr <= '0;
      store_count  <= '0;
    end else begin
      exc_ades <= fault;
      if (fault) exc_badvaddr <= addr;
      if (done)  store_count <= store_count + CNT_W'(1);
      if (good) begin
        state    <= PEND;
        dm_we    <= lane_we;
        dm_addr  <= {addr[31:2], 2'b00};
        dm_wdata <= lane_byte;
      end else if (flush || done) begin
        state <= IDLE;
        dm_we <= '0;
      end
    end
  end
endmodule

// File: tb/tb_store_byte_lane_packer.sv
// Randomized and directed bench for store_byte_lane_packer with a size/offset based reference model.

module tb_store_byte_lane_packer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       store_type = 2'b00;
  logic [31:0]      addr = '0;
  logic [31:0]      data = '0;
  logic             flush = 1'b0;
  logic             dm_en;
  logic             dm_ready = 1'b0;
  logic [3:0]       dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic             exc_ades;
  logic [31:0]      exc_badvaddr;
  logic [CNT_W-1:0] store_count;

  int checks = 0;
  int errors = 0;

  store_byte_lane_packer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .store_type(store_type), .addr(addr), .data(data), .flush(flush),
    .dm_en(dm_en), .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  // Reference model: the slot is described by size/offset arithmetic.
  logic             m_pend = 1'b0;
  logic [3:0]       m_we = '0;
  logic [31:0]      m_addr = '0, m_wdata = '0, m_bad = '0;
  logic             m_exc = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic int size_of(input logic [1:0] t);
    case (t)
      2'b00: return 4;
      2'b01: return 2;
      2'b10: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_ready();
    return !flush && (!m_pend || dm_ready);
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic cyc();
    logic rdy, comp;
    int s, off;
    rdy  = model_ready();
    comp = m_pend && dm_ready;
    s    = size_of(store_type);
    off  = int'(addr % 4);
    @(posedge clk);
    if (!rst_n) begin
      m_pend = 0; m_we = '0; m_addr = '0; m_wdata = '0; m_bad = '0; m_exc = 0; m_cnt = '0;
    end else begin
      m_exc = 0;
      if (comp) m_cnt = m_cnt + 1'b1;
      if (flush || comp) begin m_pend = 0; m_we = '0; end
      if (req_valid && rdy && s != 0) begin
        if (int'(addr % s) != 0) begin
          m_exc = 1; m_bad = addr;
        end else begin
          m_pend = 1;
          m_we   = 4'(((1 << s) - 1) << off);
          m_addr = addr - 32'(off);
          for (int i = 0; i < 4; i++) m_wdata[8*i +: 8] = data[8*(i % s) +: 8];
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic fl);
    req_valid = v; store_type = t; addr = a; data = d; dm_ready = rdy; flush = fl;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 2'b00, 32'h10, 32'h1, 1, 0);
    cyc();
    checks++; if (dm_en !== 1'b0) begin errors++; $display("FAIL reset_dm_en got %0b want 0", dm_en); end
    checks++; if (dm_we !== 4'h0) begin errors++; $display("FAIL reset_dm_we got %h want 0", dm_we); end
    checks++; if ({dm_addr, dm_wdata, exc_badvaddr} !== 96'h0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", dm_addr, dm_wdata, exc_badvaddr); end
    checks++; if ({exc_ades, store_count} !== 17'h0) begin errors++; $display("FAIL reset_exc_cnt got %b %h want 0", exc_ades, store_count); end
    rst_n = 1;
    drive(0, 2'b00, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_sb();
    drive(1, 2'b10, 32'h1003, 32'hAABBCCDD, 1, 0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sb_ready got %b want 1", req_ready); end
    cyc();
    req_valid = 0;
    checks++; if ({dm_en, dm_we} !== 5'b1_1000) begin errors++; $display("FAIL sb_we got %b %b want 1 1000", dm_en, dm_we); end
    checks++; if (dm_addr !== 32'h1000 || dm_wdata !== 32'hDDDDDDDD) begin errors++; $display("FAIL sb_addr_data got %h %h want 00001000 dddddddd", dm_addr, dm_wdata); end
    cyc();
    checks++; if (dm_en !== 1'b0 || store_count !== 16'd1) begin errors++; $display("FAIL sb_complete got en=%b cnt=%0d want 0 1", dm_en, store_count); end
  endtask

  task automatic test_sh_misalign();
    drive(1, 2'b01, 32'h2002, 32'h1234ABCD, 1, 0);
    cyc();
    checks++; if (dm_we !== 4'b1100 || dm_wdata !== 32'hABCDABCD || dm_addr !== 32'h2000) begin errors++; $display("FAIL sh_pack got %b %h %h want 1100 abcdabcd 00002000", dm_we, dm_wdata, dm_addr); end
    drive(1, 2'b01, 32'h2001, 32'h55555555, 1, 0);
    cyc();
    req_valid = 0;
    checks++; if (exc_ades !== 1'b1 || exc_badvaddr !== 32'h2001) begin errors++; $display("FAIL sh_fault got %b %h want 1 00002001", exc_ades, exc_badvaddr); end
    checks++; if (dm_en !== 1'b0 || store_count !== 16'd2) begin errors++; $display("FAIL sh_fault_nowrite got en=%b cnt=%0d want 0 2", dm_en, store_count); end
    cyc();
    checks++; if (exc_ades !== 1'b0 || exc_badvaddr !== 32'h2001 || store_count !== 16'd2) begin errors++; $display("FAIL sh_pulse got %b %h %0d want 0 00002001 2", exc_ades, exc_badvaddr, store_count); end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] c0;
    c0 = store_count;
    drive(1, 2'b00, 32'h40, 32'hDEADBEEF, 0, 0);
    cyc();
    drive(1, 2'b00, 32'h80, 32'h11223344, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, req_ready); end
      cyc();
      checks++; if ({dm_en, dm_we, dm_addr, dm_wdata} !== {1'b1, 4'hF, 32'h40, 32'hDEADBEEF}) begin errors++; $display("FAIL stall_hold[%0d] got %b %b %h %h", i, dm_en, dm_we, dm_addr, dm_wdata); end
    end
    dm_ready = 1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
    cyc();
    req_valid = 0;
    checks++; if ({dm_en, dm_addr, dm_wdata} !== {1'b1, 32'h80, 32'h11223344} || store_count !== c0 + 16'd1) begin errors++; $display("FAIL b2b_load got %b %h %h cnt=%0d", dm_en, dm_addr, dm_wdata, store_count); end
    cyc();
    checks++; if (dm_en !== 1'b0 || store_count !== c0 + 16'd2) begin errors++; $display("FAIL b2b_drain got en=%b cnt=%0d want 0 %0d", dm_en, store_count, c0 + 16'd2); end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] c0;
    drive(1, 2'b00, 32'h100, 32'hCAFEF00D, 0, 0);
    cyc();
    c0 = store_count;
    drive(1, 2'b10, 32'h200, 32'h77, 0, 1);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", req_ready); end
    cyc();
    checks++; if (dm_en !== 1'b0 || dm_we !== 4'h0 || store_count !== c0) begin errors++; $display("FAIL flush_clear got en=%b we=%b cnt=%0d want 0 0 %0d", dm_en, dm_we, store_count, c0); end
    drive(0, 2'b00, 0, 0, 1, 0);
    cyc();
    checks++; if (dm_en !== 1'b0) begin errors++; $display("FAIL flush_noaccept got en=%b want 0", dm_en); end
  endtask

  task automatic test_reset_mid_pend();
    drive(1, 2'b00, 32'h300, 32'h12345678, 0, 0);
    cyc();
    req_valid = 0;
    rst_n = 0;
    cyc();
    checks++; if ({dm_en, dm_we, dm_addr, dm_wdata, exc_ades, exc_badvaddr, store_count} !== '0) begin errors++; $display("FAIL rst_pend got en=%b we=%b cnt=%0d bad=%h", dm_en, dm_we, store_count, exc_badvaddr); end
    rst_n = 1;
  endtask

  task automatic test_reserved();
    logic [CNT_W-1:0] c0;
    c0 = store_count;
    drive(1, 2'b11, 32'h401, 32'hFFFFFFFF, 1, 0);
    cyc();
    req_valid = 0;
    checks++; if (dm_en !== 1'b0 || exc_ades !== 1'b0 || store_count !== c0) begin errors++; $display("FAIL reserved got en=%b exc=%b cnt=%0d", dm_en, exc_ades, store_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      #1;
      checks++; if (req_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, req_ready, model_ready()); end
      cyc();
      checks++;
      if (dm_en !== m_pend || dm_we !== m_we || exc_ades !== m_exc ||
          exc_badvaddr !== m_bad || store_count !== m_cnt ||
          (m_pend && (dm_addr !== m_addr || dm_wdata !== m_wdata))) begin
        errors++;
        $display("FAIL rnd_out[%0d] got en=%b we=%b a=%h d=%h exc=%b bad=%h cnt=%0d want en=%b we=%b a=%h d=%h exc=%b bad=%h cnt=%0d",
                 n, dm_en, dm_we, dm_addr, dm_wdata, exc_ades, exc_badvaddr, store_count,
                 m_pend, m_we, m_addr, m_wdata, m_exc, m_bad, m_cnt);
      end
    end
    drive(0, 2'b00, 0, 0, 1, 0);
    cyc();
  endtask

  task automatic test_count_wrap();
    int guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      drive(1, 2'b10, $urandom, $urandom, 1, 0);
      cyc();
      guard++;
    end
    checks++; if (store_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff (guard=%0d)", store_count, guard); end
    req_valid = 0;
    cyc();
    checks++; if (store_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", store_count); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh_misalign();
    test_back_to_back();
    test_flush();
    test_reset_mid_pend();
    test_reserved();
    test_random();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
